tile_rd_scheduler: RTL and testbench
====================================

# tile_rd_scheduler

Upstream sequencer for the AXI4 read controller. It accepts one 2-D tile descriptor: base address, bytes per row, row count, row stride, and SRAM base word. It then issues one read command per row to the read controller, waiting for each row to finish before starting the next. It also tells the downstream SRAM writer the word offset of the current row, because the read controller restarts its SRAM address at 0 on every start.

## Interface
- AXI_ADDR_WIDTH, 32, DDR byte-address width
- AXI_DATA_WIDTH, 32, AXI data width; bytes per beat = AXI_DATA_WIDTH/8
- TRAN_BYTE_NUM_WIDTH, 16, width of bytes-per-row
- ROW_CNT_WIDTH, 12, width of row count
- STRIDE_WIDTH, 24, width of row stride in bytes
- SRAM_ADDR_WIDTH, 32, SRAM word-address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  descriptor ready; equals (state==IDLE)
- desc_base_addr_i  in  AXI_ADDR_WIDTH  DDR byte address of row 0
- desc_row_bytes_i  in  TRAN_BYTE_NUM_WIDTH  bytes per row
- desc_row_num_i  in  ROW_CNT_WIDTH  number of rows
- desc_stride_i  in  STRIDE_WIDTH  byte distance between row starts
- desc_sram_base_i  in  SRAM_ADDR_WIDTH  SRAM word address of row 0
- rd_start_o  out  1  one-cycle start pulse to the read controller
- rd_base_addr_o  out  AXI_ADDR_WIDTH  row base address; registered, stable for the whole row
- rd_byte_num_o  out  TRAN_BYTE_NUM_WIDTH  row byte count; registered
- rd_busy_i  in  1  read controller busy
- rd_error_i  in  1  read controller sticky error
- sram_row_base_o  out  SRAM_ADDR_WIDTH  SRAM word offset of the current row
- row_idx_o  out  ROW_CNT_WIDTH  index of the current row
- done_o  out  1  one-cycle pulse when the tile ends
- err_o  out  1  sticky error; cleared on the next descriptor accept

## Operation

States are IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and DONE.

- **IDLE**
  - desc_ready_o=1.
  - On desc_valid_i&&desc_ready_o, latch all descriptor fields and clear err_o and row_idx_o.
  - Load rd_base_addr_o=desc_base_addr_i, rd_byte_num_o=desc_row_bytes_i, sram_row_base_o=desc_sram_base_i, rows_left=desc_row_num_i.
  - Next state: DONE if row_bytes==0 or row_num==0 (no start is issued); otherwise ISSUE.
- **ISSUE**
  - rd_start_o=1 for exactly this cycle.
  - Next state: WAIT_BUSY.
- **WAIT_BUSY**
  - Stay until rd_busy_i==1, then go to WAIT_DONE.
- **WAIT_DONE**
  - Stay while rd_busy_i==1.
  - On rd_busy_i==0 with rd_error_i==1: set err_o and go to DONE. Remaining rows are abandoned.
  - On rd_busy_i==0, no error and rows_left==1: go to DONE.
  - On rd_busy_i==0, no error and more rows left: update the row registers (below), then go to ISSUE.
- **DONE**
  - done_o=1.
  - Next state: IDLE.

Row update applied when leaving WAIT_DONE for ISSUE:
- rd_base_addr_o += stride
- sram_row_base_o += words_per_row
- row_idx_o += 1
- rows_left -= 1

Arithmetic rules:
- words_per_row = ceil(row_bytes / (AXI_DATA_WIDTH/8)), computed once at accept.
- All address adds wrap modulo 2^width.
- Stride is zero-extended. stride < row_bytes (overlap) and stride==0 (repeat the same row) are legal.

rd_base_addr_o and rd_byte_num_o must not change from ISSUE until WAIT_DONE exits, because the read controller uses the base address combinationally across its bursts.

## Timing
- Reset values:
  - state=IDLE, so desc_ready_o=1.
  - rd_start_o=0, done_o=0, err_o=0.
  - rd_base_addr_o, rd_byte_num_o, sram_row_base_o, row_idx_o all 0.
- Descriptor accepted at edge T: rd_start_o is high in cycle T+1. The read controller raises busy at T+2.
- rd_busy_i seen low at cycle N: the next row's rd_start_o is high at N+1. Per-row overhead is 2 cycles plus the read controller's own latency.
- Last row, busy seen low at N: done_o is high at N+1 and desc_ready_o is high at N+2.
- Zero-length descriptor accepted at T: done_o is high at T+1 with no rd_start_o.
- rd_error_i is sampled only in the cycle rd_busy_i is first seen low in WAIT_DONE. The read controller has already registered a last-beat error by that cycle.
- desc_valid_i outside IDLE is ignored and desc_ready_o=0.
- Reset mid-tile returns to IDLE immediately. The read controller is reset by the same rst_n.

## Structure
- Shared package holds:
  - the state enum
  - STRB_BYTES = AXI_DATA_WIDTH/8
  - STRB_LOG2 and the clogb2 function, shared with the read controller
- No sub-module is needed. The FSM and three adders are inline.
- words_per_row = (row_bytes + STRB_BYTES-1) >> STRB_LOG2.

## Test plan
- **Three-row tile:** base 0x1000, row_bytes 64, rows 3, stride 0x400, sram_base 0x10.
  - rd_base_addr_o is 0x1000, 0x1400, 0x1800.
  - sram_row_base_o is 0x10, 0x20, 0x30.
  - Exactly 3 rd_start_o pulses, then one done_o.
- **Ragged row:** row_bytes 10 with AXI_DATA_WIDTH 32 gives words_per_row 3. Row 1 has sram_row_base_o = base+3.
- **Zero rows or zero bytes:** done_o one cycle after accept, no rd_start_o, err_o=0.
- **Error on row 1 of 4:** model asserts rd_error_i before busy falls. err_o=1, done_o pulses, no further starts, row_idx_o=1. The next accepted descriptor clears err_o.
- **Address wrap:** base 0xFFFF_FF00, stride 0x200 gives row 1 at 0x0000_0100.
- **Back-pressure and reset:** desc_valid_i held during a busy tile is not accepted until IDLE. An rst_n pulse in WAIT_DONE gives all outputs at reset values and desc_ready_o=1.

Source files
------------

// File: rtl/tile_rd_scheduler_pkg.sv
// Shared definitions for the tile read scheduler and the AXI4 read controller:
// FSM state encoding, beat-size constants and the ceil-log2 helper.
package tile_rd_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Ceiling log2; clogb2(1) = 0, clogb2(4) = 2.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_AXI_DATA_WIDTH = 32;
  localparam int STRB_BYTES         = DEF_AXI_DATA_WIDTH / 8;
  localparam int STRB_LOG2          = clogb2(STRB_BYTES);

endpackage

// File: rtl/tile_rd_scheduler_if.sv
// Descriptor, read-controller command and SRAM-writer status signals of the
// tile read scheduler, bundled with one modport per side.
interface tile_rd_scheduler_if #(
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int TRAN_BYTE_NUM_WIDTH = 16,
  parameter int ROW_CNT_WIDTH       = 12,
  parameter int STRIDE_WIDTH        = 24,
  parameter int SRAM_ADDR_WIDTH     = 32
);

  // Descriptor handshake: a descriptor transfers on a rising clk edge where
  // desc_valid_i && desc_ready_o; the producer holds every desc_* field
  // stable while desc_valid_i is high and not yet accepted.
  logic                           desc_valid_i;
  logic                           desc_ready_o;
  logic [AXI_ADDR_WIDTH-1:0]      desc_base_addr_i;
  logic [TRAN_BYTE_NUM_WIDTH-1:0] desc_row_bytes_i;
  logic [ROW_CNT_WIDTH-1:0]       desc_row_num_i;
  logic [STRIDE_WIDTH-1:0]        desc_stride_i;
  logic [SRAM_ADDR_WIDTH-1:0]     desc_sram_base_i;

  logic                           rd_start_o;
  logic [AXI_ADDR_WIDTH-1:0]      rd_base_addr_o;
  logic [TRAN_BYTE_NUM_WIDTH-1:0] rd_byte_num_o;
  logic                           rd_busy_i;
  logic                           rd_error_i;

  logic [SRAM_ADDR_WIDTH-1:0]     sram_row_base_o;
  logic [ROW_CNT_WIDTH-1:0]       row_idx_o;
  logic                           done_o;
  logic                           err_o;

  // Environment side: descriptor producer plus read controller.
  modport master (
    output desc_valid_i, desc_base_addr_i, desc_row_bytes_i, desc_row_num_i,
           desc_stride_i, desc_sram_base_i, rd_busy_i, rd_error_i,
    input  desc_ready_o, rd_start_o, rd_base_addr_o, rd_byte_num_o,
           sram_row_base_o, row_idx_o, done_o, err_o
  );

  // Scheduler side.
  modport slave (
    input  desc_valid_i, desc_base_addr_i, desc_row_bytes_i, desc_row_num_i,
           desc_stride_i, desc_sram_base_i, rd_busy_i, rd_error_i,
    output desc_ready_o, rd_start_o, rd_base_addr_o, rd_byte_num_o,
           sram_row_base_o, row_idx_o, done_o, err_o
  );

endinterface

// File: rtl/tile_rd_scheduler.sv
// Walks a 2-D tile descriptor row by row, issuing one read-controller command
// per row and tracking the SRAM word offset of the row in flight.
module tile_rd_scheduler
  import tile_rd_scheduler_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH      = DEF_AXI_DATA_WIDTH,
  parameter int TRAN_BYTE_NUM_WIDTH = 16,
  parameter int ROW_CNT_WIDTH       = 12,
  parameter int STRIDE_WIDTH        = 24,
  parameter int SRAM_ADDR_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tile_rd_scheduler_if.slave   bus,
  output state_t               state_dbg_o
);

  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int BEAT_LOG2  = clogb2(BEAT_BYTES);
  localparam int PADW       = TRAN_BYTE_NUM_WIDTH + 1;

  state_t state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0]      rd_base_addr_q;
  logic [TRAN_BYTE_NUM_WIDTH-1:0] rd_byte_num_q;
  logic [SRAM_ADDR_WIDTH-1:0]     sram_row_base_q;
  logic [ROW_CNT_WIDTH-1:0]       row_idx_q;
  logic [ROW_CNT_WIDTH-1:0]       rows_left_q;
  logic [STRIDE_WIDTH-1:0]        stride_q;
  logic [SRAM_ADDR_WIDTH-1:0]     words_per_row_q;
  logic                           err_q;

  logic                           accept;
  logic                           advance;
  logic                           set_err;
  logic                           empty_desc;
  logic [PADW-1:0]                row_bytes_pad;
  logic [SRAM_ADDR_WIDTH-1:0]     words_per_row_d;

  // Round the row up to whole beats; one extra bit keeps the carry of the pad.
  assign row_bytes_pad   = {1'b0, bus.desc_row_bytes_i} + PADW'(BEAT_BYTES - 1);
  assign words_per_row_d = SRAM_ADDR_WIDTH'(row_bytes_pad >> BEAT_LOG2);
  assign empty_desc      = (bus.desc_row_bytes_i == '0) || (bus.desc_row_num_i == '0);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    set_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.desc_valid_i) begin
          accept  = 1'b1;
          state_d = empty_desc ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.rd_busy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // The controller's error flag is only meaningful once busy has fallen.
        if (!bus.rd_busy_i) begin
          if (bus.rd_error_i) begin
            set_err = 1'b1;
            state_d = ST_DONE;
          end else if (rows_left_q == ROW_CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            advance = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rd_base_addr_q  <= '0;
      rd_byte_num_q   <= '0;
      sram_row_base_q <= '0;
      row_idx_q       <= '0;
      rows_left_q     <= '0;
      stride_q        <= '0;
      words_per_row_q <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_base_addr_q  <= bus.desc_base_addr_i;
        rd_byte_num_q   <= bus.desc_row_bytes_i;
        sram_row_base_q <= bus.desc_sram_base_i;
        rows_left_q     <= bus.desc_row_num_i;
        stride_q        <= bus.desc_stride_i;
        words_per_row_q <= words_per_row_d;
        row_idx_q       <= '0;
        err_q           <= 1'b0;
      end else if (advance) begin
        // Row registers only move here, so they stay frozen across a row.
        rd_base_addr_q  <= rd_base_addr_q + AXI_ADDR_WIDTH'(stride_q);
        sram_row_base_q <= sram_row_base_q + words_per_row_q;
        row_idx_q       <= row_idx_q + ROW_CNT_WIDTH'(1);
        rows_left_q     <= rows_left_q - ROW_CNT_WIDTH'(1);
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  assign bus.desc_ready_o    = (state_q == ST_IDLE);
  assign bus.rd_start_o      = (state_q == ST_ISSUE);
  assign bus.done_o          = (state_q == ST_DONE);
  assign bus.rd_base_addr_o  = rd_base_addr_q;
  assign bus.rd_byte_num_o   = rd_byte_num_q;
  assign bus.sram_row_base_o = sram_row_base_q;
  assign bus.row_idx_o       = row_idx_q;
  assign bus.err_o           = err_q;
  assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_tile_rd_scheduler.sv
// Directed bench for tile_rd_scheduler: table of tile descriptors with
// hand-computed results, a reactive read-controller model and a row scoreboard.
module tb_tile_rd_scheduler;
  import tile_rd_scheduler_pkg::*;

  localparam int EW = 32 + 32 + 12 + 16;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;

  tile_rd_scheduler_if bus ();

  tile_rd_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int   err_row   = -1;
  int   start_cnt = 0;
  logic [31:0] row1_addr;
  logic [31:0] row1_sram;

  typedef struct {
    logic [31:0] base;
    logic [15:0] bytes;
    logic [11:0] rows;
    logic [23:0] stride;
    logic [31:0] sram;
    int          err_row;
    int          exp_starts;
    logic        exp_err;
    logic [11:0] exp_idx;
    logic [31:0] exp_row1_addr;
    logic [31:0] exp_row1_sram;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- read-controller model ----------------
  initial begin : rd_model
    logic [31:0] a;
    logic [15:0] b;
    logic [EW-1:0] e;
    int   row;
    int   lat;
    bit   aborted;
    bit   pending;
    pending = 1'b0;
    bus.rd_busy_i  = 1'b0;
    bus.rd_error_i = 1'b0;
    forever begin
      @(negedge clk);
      if (pending && rst_n) check("row_turnaround", 64'(bus.rd_start_o | bus.done_o), 64'd1);
      pending = 1'b0;
      if (rst_n && bus.rd_start_o) begin
        start_cnt++;
        bus.rd_error_i = 1'b0;
        bus.rd_busy_i  = 1'b1;
        a   = bus.rd_base_addr_o;
        b   = bus.rd_byte_num_o;
        row = int'(bus.row_idx_o);
        if (row == 1) begin
          row1_addr = bus.rd_base_addr_o;
          row1_sram = bus.sram_row_base_o;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_start", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("row_addr",  64'(bus.rd_base_addr_o),  64'(e[91:60]));
          check("row_sram",  64'(bus.sram_row_base_o), 64'(e[59:28]));
          check("row_idx",   64'(bus.row_idx_o),       64'(e[27:16]));
          check("row_bytes", 64'(bus.rd_byte_num_o),   64'(e[15:0]));
        end
        lat     = $urandom_range(2, 5);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          check("row_addr_stable",  64'(bus.rd_base_addr_o), 64'(a));
          check("row_bytes_stable", 64'(bus.rd_byte_num_o),  64'(b));
          if (row == err_row) bus.rd_error_i = 1'b1;
          pending = 1'b1;
        end
        bus.rd_busy_i = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input vec_t v);
    int words;
    logic [31:0] addr;
    logic [31:0] sram;
    words = (int'(v.bytes) + 3) / 4;
    for (int r = 0; r < v.exp_starts; r++) begin
      addr = v.base + 32'(r) * 32'(v.stride);
      sram = v.sram + 32'(r * words);
      exp_q.push_back({addr, sram, 12'(r), v.bytes});
    end
  endtask

  task automatic drive_desc(input vec_t v);
    bus.desc_base_addr_i = v.base;
    bus.desc_row_bytes_i = v.bytes;
    bus.desc_row_num_i   = v.rows;
    bus.desc_stride_i    = v.stride;
    bus.desc_sram_base_i = v.sram;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    bit   empty;
    bit   got_done;
    v = vecs[i];
    empty = (v.exp_starts == 0);
    exp_q.delete();
    push_exp(v);
    err_row   = v.err_row;
    start_cnt = 0;
    row1_addr = '0;
    row1_sram = '0;
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", i), 64'(bus.desc_ready_o), 64'd1);
    drive_desc(v);
    bus.desc_valid_i = 1'b1;
    @(negedge clk);
    bus.desc_valid_i = 1'b0;
    // One cycle after accept: start pulse, or done for an empty tile.
    check($sformatf("v%0d_ready_busy", i), 64'(bus.desc_ready_o), 64'd0);
    check($sformatf("v%0d_start_t1", i),   64'(bus.rd_start_o),   64'(!empty));
    check($sformatf("v%0d_done_t1", i),    64'(bus.done_o),       64'(empty));
    check($sformatf("v%0d_err_clr", i),    64'(bus.err_o),        64'd0);
    got_done = empty;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      if (bus.done_o) got_done = 1'b1;
    end
    check($sformatf("v%0d_done_seen", i), 64'(got_done), 64'd1);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", i), 64'(bus.done_o),       64'd0);
    check($sformatf("v%0d_ready_back", i), 64'(bus.desc_ready_o), 64'd1);
    check($sformatf("v%0d_starts", i),     64'(start_cnt),        64'(v.exp_starts));
    check($sformatf("v%0d_err", i),        64'(bus.err_o),        64'(v.exp_err));
    check($sformatf("v%0d_last_idx", i),   64'(bus.row_idx_o),    64'(v.exp_idx));
    check($sformatf("v%0d_sb_empty", i),   64'(exp_q.size()),     64'd0);
    if (v.exp_starts >= 2) begin
      check($sformatf("v%0d_row1_addr", i), 64'(row1_addr), 64'(v.exp_row1_addr));
      check($sformatf("v%0d_row1_sram", i), 64'(row1_sram), 64'(v.exp_row1_sram));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(bus.desc_ready_o),    64'd1);
    check({tag, "_start"}, 64'(bus.rd_start_o),      64'd0);
    check({tag, "_done"},  64'(bus.done_o),          64'd0);
    check({tag, "_err"},   64'(bus.err_o),           64'd0);
    check({tag, "_addr"},  64'(bus.rd_base_addr_o),  64'd0);
    check({tag, "_bytes"}, 64'(bus.rd_byte_num_o),   64'd0);
    check({tag, "_sram"},  64'(bus.sram_row_base_o), 64'd0);
    check({tag, "_idx"},   64'(bus.row_idx_o),       64'd0);
    check({tag, "_state"}, 64'(state_dbg),           64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit   seen;
    vec_t v;
    rst_n = 1'b0;
    bus.desc_valid_i = 1'b0;
    bus.desc_base_addr_i = '0;
    bus.desc_row_bytes_i = '0;
    bus.desc_row_num_i   = '0;
    bus.desc_stride_i    = '0;
    bus.desc_sram_base_i = '0;

    //          base          bytes   rows    stride     sram          err st  err   idx     row1 addr     row1 sram
    vecs[0] = '{32'h0000_1000, 16'd64,  12'd3, 24'h000400, 32'h0000_0010, -1, 3, 1'b0, 12'd2, 32'h0000_1400, 32'h0000_0020};
    vecs[1] = '{32'h0000_2000, 16'd10,  12'd2, 24'h000010, 32'h0000_0100, -1, 2, 1'b0, 12'd1, 32'h0000_2010, 32'h0000_0103};
    vecs[2] = '{32'h0000_3000, 16'd8,   12'd0, 24'h000010, 32'h0000_0000, -1, 0, 1'b0, 12'd0, 32'h0,         32'h0};
    vecs[3] = '{32'h0000_3000, 16'd0,   12'd5, 24'h000010, 32'h0000_0000, -1, 0, 1'b0, 12'd0, 32'h0,         32'h0};
    vecs[4] = '{32'h0000_4000, 16'd16,  12'd4, 24'h000100, 32'h0000_0000,  1, 2, 1'b1, 12'd1, 32'h0000_4100, 32'h0000_0004};
    vecs[5] = '{32'hFFFF_FF00, 16'd32,  12'd2, 24'h000200, 32'hFFFF_FFFE, -1, 2, 1'b0, 12'd1, 32'h0000_0100, 32'h0000_0006};
    vecs[6] = '{32'h0000_0080, 16'd4,   12'd3, 24'h000000, 32'h0000_0007, -1, 3, 1'b0, 12'd2, 32'h0000_0080, 32'h0000_0008};
    vecs[7] = '{32'h0000_0000, 16'd100, 12'd2, 24'h000028, 32'h0000_0000, -1, 2, 1'b0, 12'd1, 32'h0000_0028, 32'h0000_0019};

    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Descriptor held valid through a busy tile, then reset in WAIT_DONE.
    v = vecs[0];
    exp_q.delete();
    push_exp(v);
    err_row   = -1;
    start_cnt = 0;
    @(negedge clk);
    drive_desc(v);
    bus.desc_valid_i = 1'b1;
    @(negedge clk);
    bus.desc_base_addr_i = 32'hDEAD_0000;
    bus.desc_row_num_i   = 12'd1;
    bus.desc_row_bytes_i = 16'd8;
    check("bp_ready_low", 64'(bus.desc_ready_o), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (state_dbg == ST_WAIT_DONE && bus.row_idx_o == 12'd1) seen = 1'b1;
    end
    check("bp_reach_row1", 64'(seen), 64'd1);
    check("bp_ready_still_low", 64'(bus.desc_ready_o), 64'd0);
    check("bp_starts", 64'(start_cnt), 64'd2);
    #2;
    rst_n = 1'b0;
    bus.desc_valid_i = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();

    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
